// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the SRAM bus arbiter: FSM encoding, port IDs, defaults.
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    typedef logic port_t;
    localparam port_t PORT_A = 1'b0;
    localparam port_t PORT_B = 1'b1;

    localparam int WAIT_STATES_DEF = 1;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester ports A/B plus the external asynchronous SRAM pins.
interface mem_bus_arbiter_if #(
    parameter int AddrBits = 16,
    parameter int DataBits = 8
);
    logic                aReq, aWe, aAck;
    logic [AddrBits-1:0] aAddr;
    logic [DataBits-1:0] aWData, aRData;
    logic                bReq, bWe, bAck;
    logic [AddrBits-1:0] bAddr;
    logic [DataBits-1:0] bWData, bRData;
    logic                busy;
    logic [AddrBits-1:0] mADDR;
    logic [DataBits-1:0] mDIN, mDOUT;
    logic                mOEN, mWE;

    modport slave (
        input  aReq, aWe, aAddr, aWData, bReq, bWe, bAddr, bWData, mDOUT,
        output aAck, aRData, bAck, bRData, busy, mADDR, mDIN, mOEN, mWE
    );

    modport master (
        output aReq, aWe, aAddr, aWData, bReq, bWe, bAddr, bWData, mDOUT,
        input  aAck, aRData, bAck, bRData, busy, mADDR, mDIN, mOEN, mWE
    );
endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the last-grant pointer only moves when en is high.
import mem_bus_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output port_t      grant
);
    port_t last;

    always_comb begin
        grant = PORT_A;
        if (req[0] && req[1]) grant = ~last;
        else if (req[1])      grant = PORT_B;
    end

    // Reset to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (rst)     last <= PORT_B;
        else if (en) last <= grant;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin SRAM bus sequencer: SETUP, WaitStates+1 strobe cycles, HOLD with Ack.
import mem_bus_pkg::*;

module mem_bus_arbiter #(
    parameter int WaitStates = WAIT_STATES_DEF,
    parameter int AddrBits   = 16,
    parameter int DataBits   = 8
) (
    input  logic             GlobalClock,
    input  logic             R,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [3:0] WS = 4'(WaitStates);

    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic                grant_en;
    port_t               grant, owner;
    logic                we_r, we_sel;
    logic [AddrBits-1:0] addr_sel;
    logic [DataBits-1:0] wdata_sel;

    rr_arbiter2 u_rr (
        .clk   (GlobalClock),
        .rst   (R),
        .req   ({bus.bReq, bus.aReq}),
        .en    (grant_en),
        .grant (grant)
    );

    assign we_sel    = (grant == PORT_B) ? bus.bWe    : bus.aWe;
    assign addr_sel  = (grant == PORT_B) ? bus.bAddr  : bus.aAddr;
    assign wdata_sel = (grant == PORT_B) ? bus.bWData : bus.aWData;
    assign bus.busy  = (state != IDLE);

    always_ff @(posedge GlobalClock) begin
        if (R) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Requests are only looked at in IDLE, so a Req held through HOLD starts a fresh access.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        grant_en = 1'b0;
        case (state)
            IDLE: if (bus.aReq || bus.bReq) begin
                grant_en = 1'b1;
                state_n  = SETUP;
            end
            SETUP: begin
                cnt_n   = WS;
                state_n = STROBE;
            end
            STROBE: if (cnt == 4'd0) state_n = HOLD;
                    else             cnt_n   = cnt - 4'd1;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes and acks are registered from the next state so the pins never glitch.
    always_ff @(posedge GlobalClock) begin
        if (R) begin
            owner      <= PORT_A;
            we_r       <= 1'b0;
            bus.mADDR  <= '0;
            bus.mDIN   <= '0;
            bus.mOEN   <= 1'b1;
            bus.mWE    <= 1'b0;
            bus.aAck   <= 1'b0;
            bus.bAck   <= 1'b0;
            bus.aRData <= '0;
            bus.bRData <= '0;
        end else begin
            if (grant_en) begin
                owner     <= grant;
                we_r      <= we_sel;
                bus.mADDR <= addr_sel;
                bus.mDIN  <= wdata_sel;
            end
            bus.mOEN <= !(state_n == STROBE && !we_r);
            bus.mWE  <=  (state_n == STROBE &&  we_r);
            bus.aAck <=  (state_n == HOLD && owner == PORT_A);
            bus.bAck <=  (state_n == HOLD && owner == PORT_B);
            if (state == STROBE && state_n == HOLD && !we_r) begin
                if (owner == PORT_A) bus.aRData <= bus.mDOUT;
                else                 bus.bRData <= bus.mDOUT;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a behavioural SRAM and reference memory.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic R;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] exp_a, exp_b;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.AddrBits(16), .DataBits(8)) bus  ();
    mem_bus_arbiter_if #(.AddrBits(16), .DataBits(8)) bus0 ();
    mem_bus_arbiter_if #(.AddrBits(16), .DataBits(8)) bus3 ();

    mem_bus_arbiter #(.WaitStates(1), .AddrBits(16), .DataBits(8)) dut  (.GlobalClock(clk), .R(R), .bus(bus));
    mem_bus_arbiter #(.WaitStates(0), .AddrBits(16), .DataBits(8)) dut0 (.GlobalClock(clk), .R(R), .bus(bus0));
    mem_bus_arbiter #(.WaitStates(3), .AddrBits(16), .DataBits(8)) dut3 (.GlobalClock(clk), .R(R), .bus(bus3));

    // SRAM model: unwritten locations return a fixed address pattern.
    logic [7:0] mem     [0:65535];
    bit         written [0:65535];
    logic [7:0] ref_mem [logic [15:0]];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h37;
    endfunction

    always @(posedge clk) if (bus.mWE) begin
        mem[bus.mADDR]     <= bus.mDIN;
        written[bus.mADDR] <= 1'b1;
    end
    assign bus.mDOUT  = written[bus.mADDR] ? mem[bus.mADDR] : pat(bus.mADDR);
    assign bus0.mDOUT = bus0.mADDR[7:0] ^ 8'hC3;
    assign bus3.mDOUT = bus3.mADDR[7:0] ^ 8'hC3;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        tick(); tick();
        tests++;
        if (bus.mADDR !== 16'h0 || bus.mDIN !== 8'h0) begin
            fails++; $display("FAIL reset_addr_data mADDR=%h mDIN=%h required 0000/00", bus.mADDR, bus.mDIN);
        end
        tests++;
        if (bus.mOEN !== 1'b1 || bus.mWE !== 1'b0) begin
            fails++; $display("FAIL reset_strobes mOEN=%b mWE=%b required 1/0", bus.mOEN, bus.mWE);
        end
        tests++;
        if (bus.aAck !== 1'b0 || bus.bAck !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL reset_ack_busy aAck=%b bAck=%b busy=%b required 0", bus.aAck, bus.bAck, bus.busy);
        end
        tests++;
        if (bus.aRData !== 8'h0 || bus.bRData !== 8'h0) begin
            fails++; $display("FAIL reset_rdata aRData=%h bRData=%h required 00", bus.aRData, bus.bRData);
        end
        R = 1'b0;
        exp_a = 8'h0; exp_b = 8'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (bus.mOEN !== 1'b1 || bus.mWE !== 1'b0 || bus.busy !== 1'b0 || bus.aAck !== 1'b0 || bus.bAck !== 1'b0) begin
                fails++; $display("FAIL idle_cycle%0d mOEN=%b mWE=%b busy=%b acks=%b%b required 1/0/0/00",
                                  i, bus.mOEN, bus.mWE, bus.busy, bus.aAck, bus.bAck);
            end
        end
    endtask

    task automatic test_port_a_write();
        bus.aWe = 1'b1; bus.aAddr = 16'h0200; bus.aWData = 8'hA5; bus.aReq = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++;
            if (bus.mADDR !== 16'h0200 || bus.mDIN !== 8'hA5) begin
                fails++; $display("FAIL awr_addr_e%0d mADDR=%h mDIN=%h required 0200/a5", k, bus.mADDR, bus.mDIN);
            end
            tests++;
            if (bus.mWE !== (k == 2 || k == 3) || bus.mOEN !== 1'b1) begin
                fails++; $display("FAIL awr_strobe_e%0d mWE=%b mOEN=%b required %b/1", k, bus.mWE, bus.mOEN, (k == 2 || k == 3));
            end
            tests++;
            if (bus.aAck !== (k == 4) || bus.bAck !== 1'b0) begin
                fails++; $display("FAIL awr_ack_e%0d aAck=%b bAck=%b required %b/0", k, bus.aAck, bus.bAck, (k == 4));
            end
            if (k == 4) bus.aReq = 1'b0;
        end
        tests++;
        if (!written[16'h0200] || mem[16'h0200] !== 8'hA5) begin
            fails++; $display("FAIL awr_mem mem[0200]=%h required a5", mem[16'h0200]);
        end
    endtask

    task automatic test_port_b_read();
        bus.bWe = 1'b0; bus.bAddr = 16'hFFFC; bus.bWData = 8'h00; bus.bReq = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++;
            if (bus.mADDR !== 16'hFFFC) begin
                fails++; $display("FAIL brd_addr_e%0d mADDR=%h required fffc", k, bus.mADDR);
            end
            tests++;
            if (bus.mOEN !== !(k == 2 || k == 3) || bus.mWE !== 1'b0) begin
                fails++; $display("FAIL brd_strobe_e%0d mOEN=%b mWE=%b required %b/0", k, bus.mOEN, bus.mWE, !(k == 2 || k == 3));
            end
            tests++;
            if (bus.bAck !== (k == 4) || bus.aAck !== 1'b0) begin
                fails++; $display("FAIL brd_ack_e%0d bAck=%b aAck=%b required %b/0", k, bus.bAck, bus.aAck, (k == 4));
            end
            if (k >= 4) begin
                tests++;
                if (bus.bRData !== 8'h34 || bus.aRData !== exp_a) begin
                    fails++; $display("FAIL brd_data_e%0d bRData=%h aRData=%h required 34/%h", k, bus.bRData, bus.aRData, exp_a);
                end
            end
            if (k == 4) bus.bReq = 1'b0;
        end
        exp_b = 8'h34;
    endtask

    task automatic test_contention();
        int port_q [$];
        int when_q [$];
        bus.aWe = 1'b0; bus.aAddr = 16'h0200;
        bus.bWe = 1'b0; bus.bAddr = 16'hFFFC;
        bus.aReq = 1'b1; bus.bReq = 1'b1;
        for (int c = 1; c <= 40 && port_q.size() < 4; c++) begin
            tick();
            if (bus.aAck && bus.bAck) begin
                tests++; fails++; $display("FAIL cont_both_ack cycle %0d both acks high", c);
            end
            if (bus.aAck || bus.bAck) begin
                port_q.push_back(bus.aAck ? 0 : 1);
                when_q.push_back(c);
                tests++;
                if (bus.aRData !== 8'hA5 || bus.bRData !== 8'h34) begin
                    fails++; $display("FAIL cont_data aRData=%h bRData=%h required a5/34", bus.aRData, bus.bRData);
                end
                if (port_q.size() == 4) begin bus.aReq = 1'b0; bus.bReq = 1'b0; end
            end
        end
        bus.aReq = 1'b0; bus.bReq = 1'b0;
        exp_a = 8'hA5;
        tests++;
        if (port_q.size() != 4) begin
            fails++; $display("FAIL cont_count acks=%0d required 4", port_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (port_q[i] != (i % 2)) begin
                    fails++; $display("FAIL cont_order idx %0d port=%0d required %0d", i, port_q[i], i % 2);
                end
                if (i > 0) begin
                    tests++;
                    if (when_q[i] - when_q[i-1] != 5) begin
                        fails++; $display("FAIL cont_spacing idx %0d gap=%0d required 5", i, when_q[i] - when_q[i-1]);
                    end
                end
            end
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bus.aWe = 1'b1; bus.aAddr = 16'h0400; bus.aWData = 8'h77; bus.aReq = 1'b1;
        tick(); tick();
        tests++;
        if (bus.mWE !== 1'b1) begin
            fails++; $display("FAIL rmid_pre mWE=%b required 1", bus.mWE);
        end
        R = 1'b1; bus.aReq = 1'b0;
        tick();
        R = 1'b0;
        exp_a = 8'h0; exp_b = 8'h0;
        tests++;
        if (bus.mWE !== 1'b0 || bus.mOEN !== 1'b1 || bus.busy !== 1'b0 || bus.aAck !== 1'b0 || bus.mADDR !== 16'h0) begin
            fails++; $display("FAIL rmid_abort mWE=%b mOEN=%b busy=%b aAck=%b mADDR=%h required 0/1/0/0/0000",
                              bus.mWE, bus.mOEN, bus.busy, bus.aAck, bus.mADDR);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (bus.aAck !== 1'b0 || bus.bAck !== 1'b0 || bus.busy !== 1'b0) begin
                fails++; $display("FAIL rmid_noack cycle %0d aAck=%b bAck=%b busy=%b required 0", i, bus.aAck, bus.bAck, bus.busy);
            end
        end
        bus.aWe = 1'b0; bus.aAddr = 16'h0200; bus.aReq = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (bus.aAck !== (k == 4)) begin
                fails++; $display("FAIL rmid_fresh_ack_e%0d aAck=%b required %b", k, bus.aAck, (k == 4));
            end
            if (k == 4) begin
                bus.aReq = 1'b0;
                tests++;
                if (bus.aRData !== 8'hA5 || bus.bRData !== 8'h0) begin
                    fails++; $display("FAIL rmid_fresh_data aRData=%h bRData=%h required a5/00", bus.aRData, bus.bRData);
                end
            end
        end
        exp_a = 8'hA5;
    endtask

    task automatic test_ws_builds();
        int w0, w3, ack0, ack3;
        for (int pass = 0; pass < 2; pass++) begin
            w0 = 0; w3 = 0; ack0 = 0; ack3 = 0;
            if (pass == 0) begin
                bus0.aWe = 1'b1; bus0.aAddr = 16'h0010; bus0.aWData = 8'h11; bus0.aReq = 1'b1;
                bus3.aWe = 1'b1; bus3.aAddr = 16'h0010; bus3.aWData = 8'h11; bus3.aReq = 1'b1;
            end else begin
                bus0.bWe = 1'b0; bus0.bAddr = 16'h0055; bus0.bReq = 1'b1;
                bus3.bWe = 1'b0; bus3.bAddr = 16'h0055; bus3.bReq = 1'b1;
            end
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (pass == 0 ? bus0.mWE : !bus0.mOEN) w0++;
                if (pass == 0 ? bus3.mWE : !bus3.mOEN) w3++;
                if ((pass == 0 ? bus0.aAck : bus0.bAck) && ack0 == 0) begin
                    ack0 = k; bus0.aReq = 1'b0; bus0.bReq = 1'b0;
                    if (pass == 1) begin
                        tests++;
                        if (bus0.bRData !== 8'h96) begin
                            fails++; $display("FAIL ws0_rdata bRData=%h required 96", bus0.bRData);
                        end
                    end
                end
                if ((pass == 0 ? bus3.aAck : bus3.bAck) && ack3 == 0) begin
                    ack3 = k; bus3.aReq = 1'b0; bus3.bReq = 1'b0;
                    if (pass == 1) begin
                        tests++;
                        if (bus3.bRData !== 8'h96) begin
                            fails++; $display("FAIL ws3_rdata bRData=%h required 96", bus3.bRData);
                        end
                    end
                end
            end
            tests++;
            if (w0 != 1 || ack0 != 3) begin
                fails++; $display("FAIL ws0_pass%0d strobe=%0d ack_edge=%0d required 1/3", pass, w0, ack0);
            end
            tests++;
            if (w3 != 4 || ack3 != 6) begin
                fails++; $display("FAIL ws3_pass%0d strobe=%0d ack_edge=%0d required 4/6", pass, w3, ack3);
            end
        end
    endtask

    // Random requester: read data must equal the last value written at that address in ack order.
    task automatic requester(input int p, input int n);
        logic        we;
        logic [15:0] a;
        logic [7:0]  d, e;
        bit          got;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            we = 1'($urandom_range(0, 1));
            a  = 16'h0300 + 16'($urandom_range(0, 7));
            d  = 8'($urandom);
            if (p == 0) begin bus.aWe = we; bus.aAddr = a; bus.aWData = d; bus.aReq = 1'b1; end
            else        begin bus.bWe = we; bus.bAddr = a; bus.bWData = d; bus.bReq = 1'b1; end
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                got = (p == 0) ? bus.aAck : bus.bAck;
            end
            tests++;
            if (!got) begin
                fails++; $display("FAIL rnd_timeout port %0d txn %0d no ack within 40 cycles", p, i);
            end else begin
                e = ref_mem.exists(a) ? ref_mem[a] : pat(a);
                if (!we) begin
                    if (p == 0) exp_a = e; else exp_b = e;
                end
                if (bus.aRData !== exp_a || bus.bRData !== exp_b || (bus.aAck && bus.bAck)) begin
                    fails++; $display("FAIL rnd_check port %0d txn %0d we=%b addr=%h aRData=%h bRData=%h acks=%b%b required %h/%h one ack",
                                      p, i, we, a, bus.aRData, bus.bRData, bus.aAck, bus.bAck, exp_a, exp_b);
                end
                if (we) ref_mem[a] = d;
            end
            if (p == 0) bus.aReq = 1'b0; else bus.bReq = 1'b0;
        end
    endtask

    task automatic test_random();
        fork
            requester(0, 20);
            requester(1, 20);
        join
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1;
        {bus.aReq, bus.aWe, bus.aAddr, bus.aWData, bus.bReq, bus.bWe, bus.bAddr, bus.bWData} = '0;
        {bus0.aReq, bus0.aWe, bus0.aAddr, bus0.aWData, bus0.bReq, bus0.bWe, bus0.bAddr, bus0.bWData} = '0;
        {bus3.aReq, bus3.aWe, bus3.aAddr, bus3.aWData, bus3.bReq, bus3.bWe, bus3.bAddr, bus3.bWData} = '0;
        test_reset();
        test_port_a_write();
        test_port_b_read();
        test_contention();
        test_reset_mid();
        test_ws_builds();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter and access sequencer for the external 64 KiB asynchronous SRAM bus (mADDR/mDIN/mDOUT/mOEN/mWE). It sits between the 6502 core (port A) and a host loader/DMA engine (port B). It grants the bus round-robin and drives one complete read or write cycle per grant, with a programmable number of strobe wait states. It returns read data and a one-cycle acknowledge to the winning requester.

## Interface
Parameters:
- WaitStates, 1, extra strobe cycles beyond the first (0..15); strobe width = WaitStates+1 cycles
- AddrBits, 16, address width
- DataBits, 8, data width

Ports:
- GlobalClock  in  1  single system clock; all state changes on rising edge
- R  in  1  reset, synchronous, active-high
- aReq  in  1  port A request; held until aAck
- aWe  in  1  port A: 1 = write, 0 = read
- aAddr  in  AddrBits  port A address
- aWData  in  DataBits  port A write data
- aAck  out  1  port A access complete, one-cycle pulse
- aRData  out  DataBits  port A read data, valid while aAck=1 and held until next port A read completes
- bReq, bWe, bAddr, bWData, bAck, bRData: same as port A, for port B
- busy  out  1  access in progress (state ≠ IDLE)
- mADDR  out  AddrBits  SRAM address
- mDIN  out  DataBits  data to SRAM
- mDOUT  in  DataBits  data from SRAM
- mOEN  out  1  SRAM output enable, active-low
- mWE  out  1  SRAM write strobe, active-high

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If any request is present, pick a winner and capture its we/addr/wdata into mADDR/mDIN and an internal owner/we register. Go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - One request → it wins.
  - Both requests → the port not granted last wins.
  - The last-grant pointer updates at grant.
- SETUP: address and data stable, no strobe. Load the wait counter with WaitStates. Go to STROBE.
- STROBE:
  - Read: mOEN=0. Write: mWE=1.
  - Decrement the counter each cycle. When the counter = 0, go to HOLD.
  - On that transition of a read, capture mDOUT into the owner's rData.
- HOLD: strobes deasserted, mADDR/mDIN unchanged, owner's Ack=1. Go to IDLE.
- Requester rule: drop Req (or present a new access) in the cycle after Ack. A Req still high in IDLE is treated as a new access.
- Requester inputs are ignored outside IDLE.
- The non-owner port's rData is never modified.

## Timing
- Reset values: state=IDLE, mADDR=0, mDIN=0, mOEN=1, mWE=0, aAck=bAck=0, aRData=bRData=0, busy=0, last-grant=B (port A wins the first tie).
- Latency, with the request sampled at edge 0:
  - SETUP after edge 1.
  - STROBE after edge 2 through edge 2+WaitStates.
  - HOLD/Ack after edge WaitStates+3.
  - IDLE after edge WaitStates+4.
- Throughput: one access per WaitStates+4 cycles. Alternating A/B under continuous contention.
- Ack never asserts on both ports in the same cycle.
- Address/data setup before strobe: 1 cycle. Hold after strobe: 1 cycle.
- mOEN and mWE are never active simultaneously. Both are registered outputs (glitch-free).
- Reset mid-access: at the next edge, all outputs return to reset values and no Ack is issued for the aborted access. A write may be truncated, which is accepted.
- Simultaneous Req arrival with the HOLD→IDLE transition: sampled on the IDLE cycle only, never in HOLD.

## Structure
- Shared package mem_bus_pkg holds:
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3)
  - port IDs (PORT_A=0, PORT_B=1)
  - default WaitStates
- Optional sub-module rr_arbiter2: 2-way round-robin grant with a last-grant register and a grant-enable input. The FSM, counter and datapath stay in mem_bus_arbiter.

## Test plan
- Reset, then idle: all outputs at reset values; mOEN=1, mWE=0 throughout 20 cycles with no requests.
- Port A write, WaitStates=1, addr 16'h0200, data 8'hA5:
  - mADDR=16'h0200 and mDIN=8'hA5 from edge 1.
  - mWE=1 for exactly 2 cycles after edges 2–3.
  - aAck pulse after edge 4.
  - Model memory holds 8'hA5.
- Port B read, addr 16'hFFFC, model returns 8'h34: mOEN=0 for 2 cycles, bAck pulse with bRData=8'h34, aRData unchanged.
- aReq and bReq raised together and held across 4 accesses: grant order A,B,A,B with Acks exactly 5 cycles apart; never both Acks high.
- R asserted in the first STROBE cycle of a write: mWE=0 and mOEN=1 at the next edge, no Ack, FSM in IDLE. A fresh request afterwards completes normally.
- WaitStates=0 and WaitStates=3 builds: strobe width 1 and 4 cycles respectively, Ack at WaitStates+3.
